// File: rtl/alu_scan_display.sv
// Sequential ALU with serial binary-to-BCD conversion and a multiplexed
// common-cathode 7-segment display with leading-zero blanking.
module alu_scan_display #(
  parameter int WIDTH       = 4,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [1:0]        op,
  output logic              busy,
  output logic              done,
  output logic              zero,
  output logic              error,
  output logic              neg,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] dig_sel
);

  localparam int RW = 2 * WIDTH;
  localparam int BW = DIGITS * 4;
  localparam int NW = $clog2(RW + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [DIGITS-1:0] SEL0 = DIGITS'(1'b1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_r, state_nx;
  logic [WIDTH-1:0] a_r, b_r;
  logic [1:0]      op_r;
  logic [RW-1:0]   bin_r, bin_step_s, value_s, a_ext_s, b_ext_s;
  logic [BW-1:0]   bcd_r, bcd_adj_s, bcd_step_s, digits_r;
  logic [NW-1:0]   iter_r;
  logic            last_iter_s, calc_err_s, calc_neg_s;
  logic            err_p_r, neg_p_r, zero_p_r;
  logic            busy_r, done_r, zero_r, error_r, neg_r;
  logic [CW-1:0]   cnt_r;
  logic [IW-1:0]   idx_r, idx_nx;
  logic [6:0]      seg_r, seg_nx;
  logic [DIGITS-1:0] sel_r;
  logic [3:0]      dv_s;
  logic            hz_s;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign last_iter_s = (iter_r == NW'(RW - 1));
  assign a_ext_s     = {{WIDTH{1'b0}}, a_r};
  assign b_ext_s     = {{WIDTH{1'b0}}, b_r};

  // Arithmetic on the latched operands, evaluated during CALC
  always_comb begin
    value_s    = {RW{1'b0}};
    calc_err_s = 1'b0;
    calc_neg_s = 1'b0;
    case (op_r)
      2'b00: value_s = a_ext_s + b_ext_s;
      2'b01: begin
        calc_neg_s = (a_r < b_r);
        value_s    = calc_neg_s ? (b_ext_s - a_ext_s) : (a_ext_s - b_ext_s);
      end
      2'b10: value_s = a_ext_s * b_ext_s;
      2'b11: begin
        if (b_r == {WIDTH{1'b0}}) begin
          calc_err_s = 1'b1;
          value_s    = {RW{1'b0}};
        end else begin
          value_s = a_ext_s / b_ext_s;
        end
      end
      default: value_s = {RW{1'b0}};
    endcase
  end

  // One shift-add-3 step: correct nibbles >= 5, then shift the binary MSB in
  always_comb begin
    bcd_adj_s = bcd_r;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_adj_s[i*4 +: 4] = (bcd_r[i*4 +: 4] >= 4'd5) ? (bcd_r[i*4 +: 4] + 4'd3)
                                                      : bcd_r[i*4 +: 4];
    end
    bcd_step_s = {bcd_adj_s[BW-2:0], bin_r[RW-1]};
    bin_step_s = {bin_r[RW-2:0], 1'b0};
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nx;
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE:    state_nx = start ? CALC : IDLE;
      CALC:    state_nx = CONV;
      CONV:    state_nx = last_iter_s ? DONE : CONV;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch, conversion datapath, result publication and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      op_r     <= 2'b00;
      bin_r    <= {RW{1'b0}};
      bcd_r    <= {BW{1'b0}};
      iter_r   <= {NW{1'b0}};
      err_p_r  <= 1'b0;
      neg_p_r  <= 1'b0;
      zero_p_r <= 1'b0;
      digits_r <= {BW{1'b0}};
      zero_r   <= 1'b0;
      error_r  <= 1'b0;
      neg_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r  <= a;
            b_r  <= b;
            op_r <= op;
          end
        end
        CALC: begin
          bin_r    <= value_s;
          bcd_r    <= {BW{1'b0}};
          iter_r   <= {NW{1'b0}};
          err_p_r  <= calc_err_s;
          neg_p_r  <= calc_neg_s;
          zero_p_r <= (value_s == {RW{1'b0}}) && !calc_err_s;
        end
        CONV: begin
          bin_r  <= bin_step_s;
          bcd_r  <= bcd_step_s;
          iter_r <= iter_r + NW'(1'b1);
          // final step: publish digits and flags on the edge entering DONE
          if (last_iter_s) begin
            digits_r <= bcd_step_s;
            zero_r   <= zero_p_r;
            error_r  <= err_p_r;
            neg_r    <= neg_p_r;
          end
        end
        default: ;
      endcase
      busy_r <= (state_nx == CALC) || (state_nx == CONV);
      done_r <= (state_nx == DONE);
    end
  end

  assign idx_nx = (idx_r == IW'(DIGITS - 1)) ? {IW{1'b0}} : (idx_r + IW'(1'b1));

  // Segment pattern for the digit about to be selected
  always_comb begin
    dv_s = 4'd0;
    hz_s = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      dv_s = (IW'(i) == idx_nx) ? digits_r[i*4 +: 4] : dv_s;
      hz_s = ((IW'(i) >= idx_nx) && (digits_r[i*4 +: 4] != 4'd0)) ? 1'b0 : hz_s;
    end
    if (error_r) begin
      seg_nx = 7'h40;
    end else if ((idx_nx != {IW{1'b0}}) && hz_s) begin
      seg_nx = 7'h00;
    end else begin
      seg_nx = seg_code(dv_s);
    end
  end

  // Refresh counter and digit scan; outputs only change on a counter wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
      idx_r <= {IW{1'b0}};
      sel_r <= ~SEL0;
      seg_r <= 7'h3F;
    end else if (cnt_r == CW'(REFRESH_DIV - 1)) begin
      cnt_r <= {CW{1'b0}};
      idx_r <= idx_nx;
      sel_r <= ~(SEL0 << idx_nx);
      seg_r <= seg_nx;
    end else begin
      cnt_r <= cnt_r + CW'(1'b1);
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign zero    = zero_r;
  assign error   = error_r;
  assign neg     = neg_r;
  assign seg     = seg_r;
  assign dig_sel = sel_r;

endmodule

// File: tb/tb_alu_scan_display.sv
// Directed self-checking bench for alu_scan_display (WIDTH=4, DIGITS=3, REFRESH_DIV=4).
module tb_alu_scan_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic [1:0] op = 2'b00;
  logic       busy, done, zero, error, neg;
  logic [6:0] seg;
  logic [2:0] dig_sel;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  alu_scan_display #(.WIDTH(4), .DIGITS(3), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .op(op),
    .busy(busy), .done(done), .zero(zero), .error(error), .neg(neg),
    .seg(seg), .dig_sel(dig_sel)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // returns the pattern of a freshly selected digit (x on timeout)
  task automatic get_digit(input int idx, output logic [6:0] s);
    logic [2:0] tgt;
    logic [2:0] one;
    int n;
    one = 3'b001;
    tgt = ~(one << idx);
    s = 7'bxxxxxxx;
    n = 0;
    while (dig_sel === tgt && n < 40) begin @(negedge clk); n++; end
    n = 0;
    while (dig_sel !== tgt && n < 40) begin @(negedge clk); n++; end
    if (dig_sel === tgt) s = seg;
  endtask

  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v,
                        input logic [1:0] top, output bit ok);
    @(negedge clk);
    a = ta; b = tb_v; op = top; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (done === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [2:0] exp_sel;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, done, zero, error, neg} !== 5'b0 || dig_sel !== 3'b110 || seg !== 7'h3F) begin
      fails++;
      $display("FAIL reset_state: got flags=%b sel=%b seg=%h, expected 00000 110 3f",
               {busy, done, zero, error, neg}, dig_sel, seg);
    end
    rst_n = 1'b1;
    for (int p = 1; p <= 12; p++) begin
      @(negedge clk);
      exp_sel = ((p / 4) % 3 == 0) ? 3'b110 : (((p / 4) % 3 == 1) ? 3'b101 : 3'b011);
      tests++;
      if (dig_sel !== exp_sel || seg !== ((exp_sel == 3'b110) ? 7'h3F : 7'h00)) begin
        fails++;
        $display("FAIL scan_p%0d: got sel=%b seg=%h, expected sel=%b", p, dig_sel, seg, exp_sel);
      end
    end
  endtask

  task automatic test_mul_latency;
    logic [6:0] s0, s1, s2;
    @(negedge clk);
    a = 4'd9; b = 4'd7; op = 2'b10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tests++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL mul_busy_c%0d: got busy=%b done=%b, expected 1 0", i + 1, busy, done);
      end
      @(negedge clk);
    end
    tests++;
    if ({busy, done, zero, error, neg} !== 5'b01000) begin
      fails++;
      $display("FAIL mul_done: got busy/done/zero/error/neg=%b, expected 01000",
               {busy, done, zero, error, neg});
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL mul_done_pulse: got done=%b, expected 0", done);
    end
    get_digit(0, s0); get_digit(1, s1); get_digit(2, s2);
    tests++;
    if ({s0, s1, s2} !== {7'h4F, 7'h7D, 7'h00}) begin
      fails++;
      $display("FAIL mul_digits: got %h %h %h, expected 4f 7d 00", s0, s1, s2);
    end
  endtask

  task automatic test_sub;
    logic [6:0] s0, s1, s2;
    bit ok;
    run_op(4'd3, 4'd5, 2'b01, ok);
    tests++;
    if (!ok || {zero, error, neg} !== 3'b001) begin
      fails++;
      $display("FAIL sub_neg_flags: got done_seen=%0d zero/error/neg=%b, expected 1 001",
               ok, {zero, error, neg});
    end
    get_digit(0, s0); get_digit(1, s1); get_digit(2, s2);
    tests++;
    if ({s0, s1, s2} !== {7'h5B, 7'h00, 7'h00}) begin
      fails++;
      $display("FAIL sub_neg_digits: got %h %h %h, expected 5b 00 00", s0, s1, s2);
    end
    run_op(4'd5, 4'd5, 2'b01, ok);
    tests++;
    if (!ok || {zero, error, neg} !== 3'b100) begin
      fails++;
      $display("FAIL sub_zero_flags: got done_seen=%0d zero/error/neg=%b, expected 1 100",
               ok, {zero, error, neg});
    end
    get_digit(0, s0); get_digit(1, s1);
    tests++;
    if ({s0, s1} !== {7'h3F, 7'h00}) begin
      fails++;
      $display("FAIL sub_zero_digits: got %h %h, expected 3f 00", s0, s1);
    end
  endtask

  task automatic test_div;
    logic [6:0] s0, s1, s2;
    bit ok;
    run_op(4'd12, 4'd0, 2'b11, ok);
    tests++;
    if (!ok || {zero, error, neg} !== 3'b010) begin
      fails++;
      $display("FAIL div0_flags: got done_seen=%0d zero/error/neg=%b, expected 1 010",
               ok, {zero, error, neg});
    end
    get_digit(0, s0); get_digit(1, s1); get_digit(2, s2);
    tests++;
    if ({s0, s1, s2} !== {7'h40, 7'h40, 7'h40}) begin
      fails++;
      $display("FAIL div0_digits: got %h %h %h, expected 40 40 40", s0, s1, s2);
    end
    run_op(4'd12, 4'd5, 2'b11, ok);
    tests++;
    if (!ok || {zero, error, neg} !== 3'b000) begin
      fails++;
      $display("FAIL div_flags: got done_seen=%0d zero/error/neg=%b, expected 1 000",
               ok, {zero, error, neg});
    end
    get_digit(0, s0); get_digit(1, s1);
    tests++;
    if ({s0, s1} !== {7'h5B, 7'h00}) begin
      fails++;
      $display("FAIL div_digits: got %h %h, expected 5b 00", s0, s1);
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] s0, s1, s2;
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    a = 4'd15; b = 4'd15; op = 2'b10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 4'd1; b = 4'd1; op = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    tests++;
    if (done_cnt - d0 !== 1) begin
      fails++;
      $display("FAIL b2b_done_count: got %0d, expected 1", done_cnt - d0);
    end
    get_digit(0, s0); get_digit(1, s1); get_digit(2, s2);
    tests++;
    if ({s0, s1, s2} !== {7'h6D, 7'h5B, 7'h5B}) begin
      fails++;
      $display("FAIL b2b_digits: got %h %h %h, expected 6d 5b 5b", s0, s1, s2);
    end
  endtask

  task automatic test_reset_mid;
    logic [6:0] s0, s1, s2;
    int d0;
    bit ok;
    d0 = done_cnt;
    @(negedge clk);
    a = 4'd9; b = 4'd9; op = 2'b10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, zero, error, neg} !== 5'b0 || dig_sel !== 3'b110 || seg !== 7'h3F) begin
      fails++;
      $display("FAIL mid_reset_state: got flags=%b sel=%b seg=%h, expected 00000 110 3f",
               {busy, done, zero, error, neg}, dig_sel, seg);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    tests++;
    if (done_cnt !== d0) begin
      fails++;
      $display("FAIL mid_reset_no_done: got %0d dones, expected 0", done_cnt - d0);
    end
    run_op(4'd6, 4'd7, 2'b00, ok);
    tests++;
    if (!ok || {zero, error, neg} !== 3'b000) begin
      fails++;
      $display("FAIL post_reset_op: got done_seen=%0d zero/error/neg=%b, expected 1 000",
               ok, {zero, error, neg});
    end
    get_digit(0, s0); get_digit(1, s1); get_digit(2, s2);
    tests++;
    if ({s0, s1, s2} !== {7'h4F, 7'h06, 7'h00}) begin
      fails++;
      $display("FAIL post_reset_digits: got %h %h %h, expected 4f 06 00", s0, s1, s2);
    end
  endtask

  initial begin
    test_reset();
    test_mul_latency();
    test_sub();
    test_div();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
